// File: rtl/ssd1306_pkg.sv
// Shared constants for the SSD1306-style SPI receiver:
// opcodes, addressing-mode encoding, parser states and reset values.
package ssd1306_pkg;

    typedef enum logic [1:0] {
        MODE_HORIZ = 2'd0,
        MODE_VERT  = 2'd1,
        MODE_PAGE  = 2'd2
    } addr_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARG1 = 2'd1,
        ST_ARG2 = 2'd2
    } cmd_state_e;

    localparam logic [7:0] OP_DISP_OFF  = 8'hAE;
    localparam logic [7:0] OP_DISP_ON   = 8'hAF;
    localparam logic [7:0] OP_NORMAL    = 8'hA6;
    localparam logic [7:0] OP_INVERT    = 8'hA7;
    localparam logic [7:0] OP_CONTRAST  = 8'h81;
    localparam logic [7:0] OP_ADDR_MODE = 8'h20;
    localparam logic [7:0] OP_COL_ADDR  = 8'h21;
    localparam logic [7:0] OP_PAGE_ADDR = 8'h22;

    localparam logic [7:0] RST_CONTRAST   = 8'h7F;
    localparam addr_mode_e RST_MODE       = MODE_PAGE;
    localparam logic [6:0] RST_COL_START  = 7'd0;
    localparam logic [2:0] RST_PAGE_START = 3'd0;

endpackage

// File: rtl/oled_ssd1306_rx_if.sv
// Received-byte bundle between the SPI front end and the
// command/data parser.
interface oled_ssd1306_rx_if;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       dc;

    modport master (output byte_valid, output byte_data, output dc);
    modport slave  (input  byte_valid, input  byte_data, input  dc);
endinterface

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave front end: input synchronizers, scl edge
// detection and MSB-first byte assembly.
module spi_slave_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               scl_i,
    input  logic               mosi_i,
    input  logic               cs_n_i,
    input  logic               dc_i,
    oled_ssd1306_rx_if.master  rx
);

    logic [SYNC_STAGES-1:0] scl_sync_q, mosi_sync_q, cs_sync_q, dc_sync_q;
    logic                   scl_prev_q, scl_prev_d;
    logic [6:0]             shift_q, shift_d;
    logic [2:0]             cnt_q, cnt_d;
    logic                   valid_q, valid_d;
    logic [7:0]             byte_q, byte_d;
    logic                   dc_q, dc_d;
    logic                   scl_s, mosi_s, cs_s, dc_s, rise;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_sync_q  <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '1;
            dc_sync_q   <= '0;
            scl_prev_q  <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            byte_q      <= '0;
            dc_q        <= 1'b0;
        end else begin
            scl_sync_q  <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
            dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], dc_i};
            scl_prev_q  <= scl_prev_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            byte_q      <= byte_d;
            dc_q        <= dc_d;
        end
    end

    assign scl_s  = scl_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign dc_s   = dc_sync_q[SYNC_STAGES-1];
    assign rise   = scl_s & ~scl_prev_q;

    always_comb begin
        scl_prev_d = scl_s;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        valid_d    = 1'b0;
        byte_d     = byte_q;
        dc_d       = dc_q;
        if (cs_s) begin
            cnt_d = '0;
        end else if (rise) begin
            shift_d = {shift_q[5:0], mosi_s};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                valid_d = 1'b1;
                byte_d  = {shift_q, mosi_s};
                dc_d    = dc_s;
            end
        end
    end

    assign rx.byte_valid = valid_q;
    assign rx.byte_data  = byte_q;
    assign rx.dc         = dc_q;

endmodule

// File: rtl/oled_ssd1306_rx.sv
// SSD1306-compatible SPI receiver: command parser, display
// settings and framebuffer write pointer generation.
module oled_ssd1306_rx
    import ssd1306_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int COLS        = 128,
    parameter int PAGES       = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       scl_i,
    input  logic       mosi_i,
    input  logic       cs_n_i,
    input  logic       dc_i,
    output logic       fb_we_o,
    output logic [9:0] fb_addr_o,
    output logic [7:0] fb_data_o,
    output logic       display_on_o,
    output logic       invert_o,
    output logic [7:0] contrast_o
);

    localparam logic [6:0] RST_COL_END  = 7'(COLS - 1);
    localparam logic [2:0] RST_PAGE_END = 3'(PAGES - 1);

    oled_ssd1306_rx_if rx_bus ();

    spi_slave_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .scl_i  (scl_i),
        .mosi_i (mosi_i),
        .cs_n_i (cs_n_i),
        .dc_i   (dc_i),
        .rx     (rx_bus.master)
    );

    cmd_state_e state_q, state_d;
    addr_mode_e mode_q, mode_d;
    logic [7:0] opcode_q, opcode_d;
    logic [6:0] col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
    logic [2:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
    logic       we_q, we_d, disp_q, disp_d, inv_q, inv_d;
    logic [9:0] addr_q, addr_d;
    logic [7:0] data_q, data_d, contrast_q, contrast_d;
    logic [7:0] b;

    assign b = rx_bus.byte_data;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            mode_q       <= RST_MODE;
            opcode_q     <= '0;
            col_q        <= '0;
            col_start_q  <= RST_COL_START;
            col_end_q    <= RST_COL_END;
            page_q       <= '0;
            page_start_q <= RST_PAGE_START;
            page_end_q   <= RST_PAGE_END;
            we_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            disp_q       <= 1'b0;
            inv_q        <= 1'b0;
            contrast_q   <= RST_CONTRAST;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            opcode_q     <= opcode_d;
            col_q        <= col_d;
            col_start_q  <= col_start_d;
            col_end_q    <= col_end_d;
            page_q       <= page_d;
            page_start_q <= page_start_d;
            page_end_q   <= page_end_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            disp_q       <= disp_d;
            inv_q        <= inv_d;
            contrast_q   <= contrast_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        opcode_d     = opcode_q;
        col_d        = col_q;
        col_start_d  = col_start_q;
        col_end_d    = col_end_q;
        page_d       = page_q;
        page_start_d = page_start_q;
        page_end_d   = page_end_q;
        we_d         = 1'b0;
        addr_d       = addr_q;
        data_d       = data_q;
        disp_d       = disp_q;
        inv_d        = inv_q;
        contrast_d   = contrast_q;
        if (rx_bus.byte_valid && rx_bus.dc) begin
            // data always wins: any pending command is dropped
            state_d = ST_IDLE;
            we_d    = 1'b1;
            addr_d  = 10'(page_q) * 10'(COLS) + 10'(col_q);
            data_d  = b;
            unique case (mode_q)
                MODE_HORIZ: begin
                    if (col_q == col_end_q) begin
                        col_d  = col_start_q;
                        page_d = (page_q == page_end_q) ? page_start_q
                                                        : page_q + 3'd1;
                    end else begin
                        col_d = col_q + 7'd1;
                    end
                end
                MODE_VERT: begin
                    if (page_q == page_end_q) begin
                        page_d = page_start_q;
                        col_d  = (col_q == col_end_q) ? col_start_q
                                                      : col_q + 7'd1;
                    end else begin
                        page_d = page_q + 3'd1;
                    end
                end
                default: begin
                    col_d = (col_q == col_end_q) ? col_start_q
                                                 : col_q + 7'd1;
                end
            endcase
        end else if (rx_bus.byte_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    unique case (1'b1)
                        b == OP_DISP_OFF:    disp_d = 1'b0;
                        b == OP_DISP_ON:     disp_d = 1'b1;
                        b == OP_NORMAL:      inv_d  = 1'b0;
                        b == OP_INVERT:      inv_d  = 1'b1;
                        b[7:3] == 5'b10110:  page_d = b[2:0];
                        b[7:4] == 4'h0:      col_d  = {col_q[6:4], b[3:0]};
                        b[7:4] == 4'h1:      col_d  = {b[2:0], col_q[3:0]};
                        b == OP_CONTRAST || b == OP_ADDR_MODE ||
                        b == OP_COL_ADDR || b == OP_PAGE_ADDR: begin
                            opcode_d = b;
                            state_d  = ST_ARG1;
                        end
                        default: ;
                    endcase
                end
                ST_ARG1: begin
                    state_d = ST_IDLE;
                    unique case (opcode_q)
                        OP_CONTRAST: contrast_d = b;
                        OP_ADDR_MODE: begin
                            if (b[1:0] != 2'b11) mode_d = addr_mode_e'(b[1:0]);
                        end
                        OP_COL_ADDR: begin
                            col_start_d = b[6:0];
                            col_d       = b[6:0];
                            state_d     = ST_ARG2;
                        end
                        OP_PAGE_ADDR: begin
                            page_start_d = b[2:0];
                            page_d       = b[2:0];
                            state_d      = ST_ARG2;
                        end
                        default: ;
                    endcase
                end
                default: begin
                    state_d = ST_IDLE;
                    if (opcode_q == OP_COL_ADDR)  col_end_d  = b[6:0];
                    if (opcode_q == OP_PAGE_ADDR) page_end_d = b[2:0];
                end
            endcase
        end
    end

    assign fb_we_o      = we_q;
    assign fb_addr_o    = addr_q;
    assign fb_data_o    = data_q;
    assign display_on_o = disp_q;
    assign invert_o     = inv_q;
    assign contrast_o   = contrast_q;

endmodule

// File: tb/tb_oled_ssd1306_rx.sv
// Directed bench for oled_ssd1306_rx: SPI byte driver, write
// capture queue and hand-computed expectations.
module tb_oled_ssd1306_rx;

    logic       clk_i  = 1'b0;
    logic       rst_i  = 1'b1;
    logic       scl_i  = 1'b0;
    logic       mosi_i = 1'b0;
    logic       cs_n_i = 1'b1;
    logic       dc_i   = 1'b0;
    logic       fb_we_o;
    logic [9:0] fb_addr_o;
    logic [7:0] fb_data_o;
    logic       display_on_o;
    logic       invert_o;
    logic [7:0] contrast_o;

    int nvec = 0;
    int nbad = 0;
    logic [9:0] wa[$];
    logic [7:0] wd[$];

    oled_ssd1306_rx dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .scl_i        (scl_i),
        .mosi_i       (mosi_i),
        .cs_n_i       (cs_n_i),
        .dc_i         (dc_i),
        .fb_we_o      (fb_we_o),
        .fb_addr_o    (fb_addr_o),
        .fb_data_o    (fb_data_o),
        .display_on_o (display_on_o),
        .invert_o     (invert_o),
        .contrast_o   (contrast_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (fb_we_o) begin
            wa.push_back(fb_addr_o);
            wd.push_back(fb_data_o);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_wr(input string tag, input int i,
                            input logic [9:0] a, input logic [7:0] d);
        if (i < wa.size()) begin
            check_eq({tag, "_addr"}, 32'(wa[i]), 32'(a));
            check_eq({tag, "_data"}, 32'(wd[i]), 32'(d));
        end else begin
            check_eq({tag, "_count"}, wa.size(), i + 1);
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, input logic dc);
        cs_n_i = 1'b0;
        dc_i   = dc;
        #40;
        for (int i = 7; i > 7 - n; i--) begin
            mosi_i = b[i];
            #40 scl_i = 1'b1;
            #80 scl_i = 1'b0;
            #40;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dc);
        send_bits(b, 8, dc);
        cs_n_i = 1'b1;
        #100;
    endtask

    task automatic do_reset();
        cs_n_i = 1'b1;
        scl_i  = 1'b0;
        rst_i  = 1'b1;
        #23;
        rst_i  = 1'b0;
        #20;
        wa.delete();
        wd.delete();
    endtask

    initial begin
        #23;
        check_eq("rst_we", fb_we_o, 0);
        check_eq("rst_addr", fb_addr_o, 0);
        check_eq("rst_data", fb_data_o, 0);
        check_eq("rst_disp", display_on_o, 0);
        check_eq("rst_inv", invert_o, 0);
        check_eq("rst_contrast", contrast_o, 8'h7F);
        rst_i = 1'b0;
        #20;

        // display on, single write at origin
        send_byte(8'hAF, 1'b0);
        send_byte(8'h55, 1'b1);
        check_eq("t1_disp", display_on_o, 1);
        check_eq("t1_nwr", wa.size(), 1);
        check_wr("t1_w0", 0, 10'h000, 8'h55);

        // horizontal window col 10..11, page 2..3
        do_reset();
        send_byte(8'h20, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h21, 1'b0); send_byte(8'h10, 1'b0); send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0);
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
        check_eq("t2_nwr", wa.size(), 5);
        check_wr("t2_w0", 0, 10'h110, 8'h01);
        check_wr("t2_w1", 1, 10'h111, 8'h02);
        check_wr("t2_w2", 2, 10'h190, 8'h03);
        check_wr("t2_w3", 3, 10'h191, 8'h04);
        check_wr("t2_w4", 4, 10'h110, 8'h05);

        // vertical window col 0..127, page 6..7
        do_reset();
        send_byte(8'h20, 1'b0); send_byte(8'h01, 1'b0);
        send_byte(8'h21, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h7F, 1'b0);
        send_byte(8'h22, 1'b0); send_byte(8'h06, 1'b0); send_byte(8'h07, 1'b0);
        send_byte(8'hC1, 1'b1); send_byte(8'hC2, 1'b1); send_byte(8'hC3, 1'b1);
        check_eq("t3_nwr", wa.size(), 3);
        check_wr("t3_w0", 0, 10'h300, 8'hC1);
        check_wr("t3_w1", 1, 10'h380, 8'hC2);
        check_wr("t3_w2", 2, 10'h301, 8'hC3);

        // data byte aborts pending contrast command
        do_reset();
        send_byte(8'h81, 1'b0);
        send_byte(8'hAA, 1'b1);
        check_eq("t4_contrast", contrast_o, 8'h7F);
        check_wr("t4_w0", 0, 10'h000, 8'hAA);
        send_byte(8'hA7, 1'b0);
        check_eq("t4_inv", invert_o, 1);
        check_eq("t4_nwr", wa.size(), 1);
        send_byte(8'h81, 1'b0); send_byte(8'h40, 1'b0);
        check_eq("t4_contrast_set", contrast_o, 8'h40);
        send_byte(8'hA6, 1'b0); send_byte(8'hAE, 1'b0);
        check_eq("t4_inv_off", invert_o, 0);
        check_eq("t4_disp_off", display_on_o, 0);

        // partial byte discarded on cs_n high
        do_reset();
        send_bits(8'hFF, 5, 1'b1);
        cs_n_i = 1'b1;
        #100;
        send_byte(8'h3C, 1'b1);
        check_eq("t5_nwr", wa.size(), 1);
        check_wr("t5_w0", 0, 10'h000, 8'h3C);

        // reset during second argument of 21
        do_reset();
        send_byte(8'h21, 1'b0); send_byte(8'h05, 1'b0);
        send_bits(8'h7F, 4, 1'b0);
        do_reset();
        send_byte(8'h11, 1'b1);
        send_byte(8'h0F, 1'b0); send_byte(8'h17, 1'b0);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        check_eq("t6_nwr", wa.size(), 3);
        check_wr("t6_w0", 0, 10'h000, 8'h11);
        check_wr("t6_w1", 1, 10'h07F, 8'h22);
        check_wr("t6_w2", 2, 10'h000, 8'h33);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
